updown_counter_mod: RTL



---
 rtl/updown_counter_mod.sv | 84 ++++++++
 1 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised modulo up/down counter with runtime limit, parallel load and boundary flag.
// Optional saturating mode is compiled in when UPDOWN_COUNTER_SAT_EN is defined (adds port sat).
module updown_counter_mod #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = 4
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          en,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          down,
    input  logic [SW-1:0] step,
    input  logic [W-1:0]  limit,
`ifdef UPDOWN_COUNTER_SAT_EN
    input  logic          sat,
`endif
    output logic [W-1:0]  out,
    output logic          wrap,
    output logic          zero
);

    localparam logic [W-1:0] OneW = 1;

    logic [W-1:0] out_q, out_d;
    logic         wrap_q, wrap_d;
    logic         sat_en;
    logic [W-1:0] step_w, s_w;
    logic [W:0]   sum;

`ifdef UPDOWN_COUNTER_SAT_EN
    assign sat_en = sat;
`else
    assign sat_en = 1'b0;
`endif

    // Step is clamped to the limit so a single move never spans more than one modulo period.
    assign step_w = W'(step);
    assign s_w    = (step_w > limit) ? limit : step_w;
    assign sum    = {1'b0, out_q} + {1'b0, s_w};

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            out_d = (load_val > limit) ? limit : load_val;
        end else if (en) begin
            if (out_q > limit) begin
                out_d  = sat_en ? limit : '0;
                wrap_d = 1'b1;
            end else if (!down) begin
                if (sum > {1'b0, limit}) begin
                    // Result is below limit+1, so W-bit modular arithmetic is exact.
                    out_d  = sat_en ? limit : (out_q + s_w - limit - OneW);
                    wrap_d = 1'b1;
                end else begin
                    out_d = sum[W-1:0];
                end
            end else begin
                if (s_w > out_q) begin
                    out_d  = sat_en ? '0 : (out_q + limit + OneW - s_w);
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q - s_w;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;
    assign zero = (out_q == '0);

endmodule
